// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings, request record and sizing helper for the calculator front end
package calc_pkg;

    localparam int CALC_CMD_W  = 4;
    localparam int CALC_TAG_W  = 2;
    localparam int CALC_DATA_W = 32;

    typedef enum logic [CALC_CMD_W-1:0] {
        CMD_IDLE = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_SHL  = 4'd5,
        CMD_SHR  = 4'd6
    } calc_cmd_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_OK   = 2'd1,
        RSP_ERR  = 2'd2,
        RSP_RSVD = 2'd3
    } calc_rsp_e;

    typedef enum logic {
        CAP_IDLE,
        CAP_OP2
    } cap_st_e;

    typedef struct packed {
        logic [CALC_CMD_W-1:0]  cmd;
        logic [CALC_TAG_W-1:0]  tag;
        logic [CALC_DATA_W-1:0] op1;
        logic [CALC_DATA_W-1:0] op2;
    } calc_req_t;

    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/calc_port_fifo.sv
// calc_port_fifo: per-port synchronous request FIFO with occupancy count
module calc_port_fifo
    import calc_pkg::*;
#(
    parameter type T     = calc_req_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       data_i,
    output T                       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/calc_req_arbiter.sv
// calc_req_arbiter: per-port two-cycle request capture with duplicate-tag check,
// per-port queuing, round-robin engine issue and response routing back to ports
module calc_req_arbiter
    import calc_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int CMD_W      = CALC_CMD_W,
    parameter int TAG_W      = CALC_TAG_W,
    parameter int DATA_W     = CALC_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*CMD_W-1:0]    req_cmd_in,
    input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
    output logic [NUM_PORTS-1:0]          req_stall,
    output logic                          eng_valid,
    input  logic                          eng_ready,
    output logic [port_w(NUM_PORTS)-1:0]  eng_port,
    output logic [CMD_W-1:0]              eng_cmd,
    output logic [TAG_W-1:0]              eng_tag,
    output logic [DATA_W-1:0]             eng_op1,
    output logic [DATA_W-1:0]             eng_op2,
    input  logic                          eng_rsp_valid,
    input  logic [port_w(NUM_PORTS)-1:0]  eng_rsp_port,
    input  logic [TAG_W-1:0]              eng_rsp_tag,
    input  logic [1:0]                    eng_rsp_code,
    input  logic [DATA_W-1:0]             eng_rsp_data,
    output logic [NUM_PORTS*2-1:0]        out_resp,
    output logic [NUM_PORTS*TAG_W-1:0]    out_tag,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data
);

    localparam int PW = port_w(NUM_PORTS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    req_t                 head [NUM_PORTS];
    logic [NUM_PORTS-1:0] nonempty;
    logic [PW-1:0]        rr_q, rr_d, lport_q, lport_d, gnt, srch, k;
    logic                 lock_q, lock_d, found, xfer;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        cap_st_e             st_q, st_d;
        req_t                cap_q, cap_d, push_data;
        logic                dup_q, dup_d, perr_q, perr_d, hit, cap, push, pop;
        logic [2**TAG_W-1:0] infl_q, infl_d;
        logic [1:0]          resp_q, resp_d;
        logic [TAG_W-1:0]    otag_q, otag_d, tag;
        logic [DATA_W-1:0]   odata_q, odata_d, data;
        logic [CMD_W-1:0]    cmd;
        logic [CW-1:0]       cnt;
        logic [CW:0]         occ;

        assign cmd  = req_cmd_in[g*CMD_W +: CMD_W];
        assign tag  = req_tag_in[g*TAG_W +: TAG_W];
        assign data = req_data_in[g*DATA_W +: DATA_W];
        assign hit  = eng_rsp_valid && eng_rsp_port == PW'(g);
        // an in-progress capture already owns a FIFO slot
        assign occ  = {1'b0, cnt} + {{CW{1'b0}}, st_q == CAP_OP2};
        assign req_stall[g] = occ >= (CW+1)'(FIFO_DEPTH) || perr_q;
        assign cap  = st_q == CAP_IDLE && cmd != '0 && !req_stall[g];
        assign push = st_q == CAP_OP2 && !dup_q;
        assign pop  = xfer && gnt == PW'(g);
        assign nonempty[g] = cnt != '0;

        always_comb begin
            st_d          = cap ? CAP_OP2 : CAP_IDLE;
            cap_d         = cap ? {cmd, tag, data, {DATA_W{1'b0}}} : cap_q;
            dup_d         = cap ? infl_q[tag] : dup_q;
            perr_d        = (st_q == CAP_OP2 && dup_q) || (perr_q && hit);
            resp_d        = hit ? eng_rsp_code : (perr_q ? RSP_ERR : RSP_NONE);
            otag_d        = hit ? eng_rsp_tag : (perr_q ? cap_q.tag : '0);
            odata_d       = hit ? eng_rsp_data : '0;
            push_data     = cap_q;
            push_data.op2 = data;
            infl_d        = infl_q;
            if (hit) infl_d[eng_rsp_tag] = 1'b0;
            if (push) infl_d[cap_q.tag] = 1'b1;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_q    <= CAP_IDLE;
                cap_q   <= '0;
                dup_q   <= 1'b0;
                perr_q  <= 1'b0;
                infl_q  <= '0;
                resp_q  <= '0;
                otag_q  <= '0;
                odata_q <= '0;
            end else begin
                st_q    <= st_d;
                cap_q   <= cap_d;
                dup_q   <= dup_d;
                perr_q  <= perr_d;
                infl_q  <= infl_d;
                resp_q  <= resp_d;
                otag_q  <= otag_d;
                odata_q <= odata_d;
            end
        end

        calc_port_fifo #(.T(req_t), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push),
            .pop_i   (pop),
            .data_i  (push_data),
            .data_o  (head[g]),
            .count_o (cnt)
        );

        assign out_resp[g*2 +: 2]         = resp_q;
        assign out_tag[g*TAG_W +: TAG_W]  = otag_q;
        assign out_data[g*DATA_W +: DATA_W] = odata_q;
    end

    always_comb begin
        srch  = rr_q;
        found = 1'b0;
        k     = rr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && nonempty[k]) begin
                found = 1'b1;
                srch  = k;
            end
            k = (k == PW'(NUM_PORTS - 1)) ? '0 : k + 1'b1;
        end
    end

    assign eng_valid = |nonempty;
    assign gnt       = lock_q ? lport_q : srch;
    assign xfer      = eng_valid && eng_ready;
    assign eng_port  = eng_valid ? gnt : '0;
    assign eng_cmd   = eng_valid ? head[gnt].cmd : '0;
    assign eng_tag   = eng_valid ? head[gnt].tag : '0;
    assign eng_op1   = eng_valid ? head[gnt].op1 : '0;
    assign eng_op2   = eng_valid ? head[gnt].op2 : '0;

    always_comb begin
        lock_d  = eng_valid && !eng_ready;
        lport_d = gnt;
        rr_d    = !xfer ? rr_q : (gnt == PW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q    <= '0;
            lock_q  <= 1'b0;
            lport_q <= '0;
        end else begin
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            lport_q <= lport_d;
        end
    end

endmodule

// File: tb/tb_calc_req_arbiter.sv
// tb_calc_req_arbiter: scoreboard bench; stimulus queues expected issues/responses,
// a negedge monitor pops and compares whatever the DUT presents
module tb_calc_req_arbiter;

    typedef struct packed {
        logic [1:0]  port;
        logic [3:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
    } iss_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [1:0]  code;
        logic [1:0]  tag;
        logic [31:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   req_cmd_in;
    logic [7:0]    req_tag_in;
    logic [127:0]  req_data_in;
    logic [3:0]    req_stall;
    logic          eng_valid, eng_ready;
    logic [1:0]    eng_port;
    logic [3:0]    eng_cmd;
    logic [1:0]    eng_tag;
    logic [31:0]   eng_op1, eng_op2;
    logic          eng_rsp_valid;
    logic [1:0]    eng_rsp_port, eng_rsp_tag, eng_rsp_code;
    logic [31:0]   eng_rsp_data;
    logic [7:0]    out_resp;
    logic [7:0]    out_tag;
    logic [127:0]  out_data;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    calc_req_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_cmd_in    (req_cmd_in),
        .req_tag_in    (req_tag_in),
        .req_data_in   (req_data_in),
        .req_stall     (req_stall),
        .eng_valid     (eng_valid),
        .eng_ready     (eng_ready),
        .eng_port      (eng_port),
        .eng_cmd       (eng_cmd),
        .eng_tag       (eng_tag),
        .eng_op1       (eng_op1),
        .eng_op2       (eng_op2),
        .eng_rsp_valid (eng_rsp_valid),
        .eng_rsp_port  (eng_rsp_port),
        .eng_rsp_tag   (eng_rsp_tag),
        .eng_rsp_code  (eng_rsp_code),
        .eng_rsp_data  (eng_rsp_data),
        .out_resp      (out_resp),
        .out_tag       (out_tag),
        .out_data      (out_data)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [3:0] c, input logic [1:0] t, input logic [31:0] d);
        req_cmd_in[p*4 +: 4]    = c;
        req_tag_in[p*2 +: 2]    = t;
        req_data_in[p*32 +: 32] = d;
    endtask

    task automatic req(input int p, input logic [3:0] c, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] b);
        set_req(p, c, t, a);
        cyc();
        set_req(p, 4'd0, 2'd0, b);
        cyc();
        set_req(p, 4'd0, 2'd0, 32'd0);
    endtask

    task automatic drive_rsp(input int p, input logic [1:0] code, input logic [1:0] t, input logic [31:0] d);
        eng_rsp_valid = 1'b1;
        eng_rsp_port  = 2'(p);
        eng_rsp_code  = code;
        eng_rsp_tag   = t;
        eng_rsp_data  = d;
        rsp_q.push_back('{2'(p), code, t, d});
    endtask

    task automatic respond(input int p, input logic [1:0] code, input logic [1:0] t, input logic [31:0] d);
        drive_rsp(p, code, t, d);
        cyc();
        eng_rsp_valid = 1'b0;
    endtask

    task automatic settle(input string nm);
        repeat (8) cyc();
        chk({nm, "_issue_left"}, 128'(iss_q.size()), 128'd0);
        chk({nm, "_resp_left"}, 128'(rsp_q.size()), 128'd0);
    endtask

    initial begin : monitor
        iss_t ie;
        rsp_t re;
        forever begin
            @(negedge clk);
            if (eng_valid && eng_ready) begin
                if (iss_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL issue_unexpected: got port %0d tag %0d, expected no issue", eng_port, eng_tag);
                end else begin
                    ie = iss_q.pop_front();
                    chk("issue", {eng_port, eng_cmd, eng_tag, eng_op1, eng_op2}, ie);
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (out_resp[p*2 +: 2] != 2'd0) begin
                    if (rsp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL resp_unexpected: got port %0d code %0d tag %0d, expected none",
                                 p, out_resp[p*2 +: 2], out_tag[p*2 +: 2]);
                    end else begin
                        re = rsp_q.pop_front();
                        chk("resp", {2'(p), out_resp[p*2 +: 2], out_tag[p*2 +: 2], out_data[p*32 +: 32]}, re);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        req_cmd_in    = '0;
        req_tag_in    = '0;
        req_data_in   = '0;
        eng_ready     = 1'b0;
        eng_rsp_valid = 1'b0;
        eng_rsp_port  = '0;
        eng_rsp_tag   = '0;
        eng_rsp_code  = '0;
        eng_rsp_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_eng", {eng_valid, eng_port, eng_cmd, eng_tag, eng_op1, eng_op2}, '0);
        chk("rst_stall", req_stall, '0);
        chk("rst_out", {out_resp, out_tag, out_data[63:0]}, '0);
        reset = 1'b1;
        cyc();

        // round robin from pointer 0
        eng_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            iss_q.push_back('{2'(p), 4'd1, 2'd0, 32'(10 + p), 32'(20 + p)});
            set_req(p, 4'd1, 2'd0, 32'(10 + p));
        end
        cyc();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 2'd0, 32'(20 + p));
        cyc();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 2'd0, 32'd0);
        settle("rr0");
        for (int p = 0; p < 4; p++) respond(p, 2'd1, 2'd0, 32'(30 + 2 * p));
        settle("rr0_rsp");

        // single port 1 request moves the pointer to 2
        iss_q.push_back('{2'd1, 4'd2, 2'd1, 32'd100, 32'd1});
        req(1, 4'd2, 2'd1, 32'd100, 32'd1);
        settle("p1");
        respond(1, 2'd1, 2'd1, 32'd99);
        settle("p1_rsp");

        // round robin from pointer 2
        for (int i = 0; i < 4; i++) begin
            automatic int p = (i + 2) % 4;
            iss_q.push_back('{2'(p), 4'd5, 2'd3, 32'(p), 32'd1});
        end
        for (int p = 0; p < 4; p++) set_req(p, 4'd5, 2'd3, 32'(p));
        cyc();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 2'd0, 32'd1);
        cyc();
        for (int p = 0; p < 4; p++) set_req(p, 4'd0, 2'd0, 32'd0);
        settle("rr2");
        for (int p = 0; p < 4; p++) respond(p, 2'd1, 2'd3, 32'(p * 2));
        settle("rr2_rsp");

        // single request with minimum-latency checks
        iss_q.push_back('{2'd0, 4'd1, 2'd2, 32'd5, 32'd7});
        set_req(0, 4'd1, 2'd2, 32'd5);
        cyc();
        chk("lat_op2_cycle", eng_valid, 1'b0);
        set_req(0, 4'd0, 2'd0, 32'd7);
        cyc();
        set_req(0, 4'd0, 2'd0, 32'd0);
        chk("lat_issue_cycle", eng_valid, 1'b1);
        settle("single");
        respond(0, 2'd1, 2'd2, 32'd12);
        settle("single_rsp");

        // backpressure on port 1
        eng_ready = 1'b0;
        for (int k = 0; k < 3; k++) req(1, 4'd6, 2'(k), 32'(200 + k), 32'(k));
        chk("bp_stall_cnt3", req_stall[1], 1'b0);
        set_req(1, 4'd6, 2'd3, 32'd203);
        cyc();
        chk("bp_stall_op2", req_stall[1], 1'b1);
        set_req(1, 4'd0, 2'd0, 32'd3);
        cyc();
        set_req(1, 4'd1, 2'd0, 32'd0);
        chk("bp_stall_full", req_stall[1], 1'b1);
        repeat (3) begin
            cyc();
            chk("bp_hold", {eng_valid, eng_port, eng_cmd, eng_tag, eng_op1, eng_op2},
                {1'b1, 2'd1, 4'd6, 2'd0, 32'd200, 32'd0});
        end
        set_req(1, 4'd0, 2'd0, 32'd0);
        cyc();
        for (int k = 0; k < 4; k++) iss_q.push_back('{2'd1, 4'd6, 2'(k), 32'(200 + k), 32'(k)});
        eng_ready = 1'b1;
        settle("bp");
        for (int k = 0; k < 4; k++) respond(1, 2'd1, 2'(k), 32'(1000 + k));
        settle("bp_rsp");

        // duplicate tag on port 3
        iss_q.push_back('{2'd3, 4'd1, 2'd1, 32'd1, 32'd2});
        req(3, 4'd1, 2'd1, 32'd1, 32'd2);
        repeat (2) cyc();
        rsp_q.push_back('{2'd3, 2'd2, 2'd1, 32'd0});
        req(3, 4'd1, 2'd1, 32'd3, 32'd4);
        chk("dup_stall", req_stall[3], 1'b1);
        settle("dup");
        respond(3, 2'd1, 2'd1, 32'd3);
        settle("dup_rsp");

        // duplicate error colliding with an engine response to the same port
        iss_q.push_back('{2'd3, 4'd1, 2'd2, 32'd7, 32'd8});
        req(3, 4'd1, 2'd2, 32'd7, 32'd8);
        repeat (2) cyc();
        set_req(3, 4'd1, 2'd2, 32'd9);
        cyc();
        set_req(3, 4'd0, 2'd0, 32'd10);
        cyc();
        set_req(3, 4'd0, 2'd0, 32'd0);
        drive_rsp(3, 2'd1, 2'd2, 32'd55);
        rsp_q.push_back('{2'd3, 2'd2, 2'd2, 32'd0});
        chk("col_stall_a", req_stall[3], 1'b1);
        cyc();
        eng_rsp_valid = 1'b0;
        chk("col_stall_b", req_stall[3], 1'b1);
        cyc();
        chk("col_stall_c", req_stall[3], 1'b0);
        settle("col");

        // tag set and clear in the same cycle leaves the bit set
        iss_q.push_back('{2'd2, 4'd1, 2'd0, 32'd40, 32'd41});
        set_req(2, 4'd1, 2'd0, 32'd40);
        cyc();
        set_req(2, 4'd0, 2'd0, 32'd41);
        drive_rsp(2, 2'd1, 2'd0, 32'd9);
        cyc();
        eng_rsp_valid = 1'b0;
        set_req(2, 4'd0, 2'd0, 32'd0);
        repeat (2) cyc();
        rsp_q.push_back('{2'd2, 2'd2, 2'd0, 32'd0});
        req(2, 4'd1, 2'd0, 32'd50, 32'd51);
        settle("setclr");
        respond(2, 2'd1, 2'd0, 32'd77);
        settle("setclr_rsp");

        // reset during OP2 with two queued entries
        eng_ready = 1'b0;
        req(0, 4'd1, 2'd0, 32'd1, 32'd1);
        req(0, 4'd1, 2'd1, 32'd2, 32'd2);
        set_req(0, 4'd1, 2'd2, 32'd3);
        cyc();
        chk("pre_rst_valid", eng_valid, 1'b1);
        set_req(0, 4'd0, 2'd0, 32'd4);
        reset = 1'b0;
        #1;
        chk("mid_rst_eng", {eng_valid, eng_port, eng_cmd, eng_tag, eng_op1, eng_op2}, '0);
        chk("mid_rst_stall", req_stall, '0);
        chk("mid_rst_out", {out_resp, out_tag, out_data[63:0]}, '0);
        set_req(0, 4'd0, 2'd0, 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_valid", eng_valid, 1'b0);
        eng_ready = 1'b1;
        iss_q.push_back('{2'd0, 4'd1, 2'd0, 32'd5, 32'd6});
        req(0, 4'd1, 2'd0, 32'd5, 32'd6);
        settle("reuse");
        respond(0, 2'd1, 2'd0, 32'd11);
        settle("reuse_rsp");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
